res_arb: RTL and testbench

RES_ARB -- requirements
Module: res_arb

---
 rtl/res_arb.sv | 192 +++++++++++++++++++
 tb/tb_res_arb.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/res_arb.sv
// res_arb -- two-requester arbiter in front of a single-port resource RAM.
//
// Each request is one beat and is arbitrated in the cycle it is presented.
// The RAM command (res_rd/res_wr/res_addr/res_do) is driven combinationally
// from the winning requester. Read data is captured one cycle later.
// A preferred requester ("prio") keeps winning for at most HOLD_MAX
// consecutive grants. After that, the other requester becomes preferred.
//
// Parameters:
//   HOLD_MAX   max consecutive grants to one requester while the other waits (1..255)
//
// Ports:
//   clk, reset                    clock, async active-high reset
//   mN_req/we/addr/wdata  (in)    requester N command, held until mN_gnt seen
//   mN_gnt                (out)   command issued to the RAM this cycle
//   mN_rvalid/rdata       (out)   read return, one cycle after a read grant
//   res_rd/wr/addr/do     (out)   RAM command
//   res_di                (in)    RAM read data (RAM updates it at negedge)
//   stall_cnt             (out)   contention counter, present only when
//                                 RES_ARB_STATS_EN is defined

// Per-requester read-return register.
module res_arb_rport (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       hit_i,
  input  logic [7:0] di_i,
  output logic       rvalid_o,
  output logic [7:0] rdata_o
);
  logic       rvalid_q;
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= hit_i;
      // Only the addressed requester's data register moves. The other one holds.
      if (hit_i) rdata_q <= di_i;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
endmodule

module res_arb #(
  parameter int HOLD_MAX = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [13:0] m0_addr,
  input  logic [7:0]  m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [7:0]  m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [13:0] m1_addr,
  input  logic [7:0]  m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [7:0]  m1_rdata,
  output logic        res_rd,
  output logic        res_wr,
  output logic [13:0] res_addr,
  output logic [7:0]  res_do,
  input  logic [7:0]  res_di
`ifdef RES_ARB_STATS_EN
  ,
  output logic [15:0] stall_cnt
`endif
);
  localparam int NUM_REQ = 2;
  localparam int CW      = $clog2(HOLD_MAX + 1);
  localparam logic [CW:0] HOLD_LIM = (CW + 1)'(HOLD_MAX);

  logic [NUM_REQ-1:0]        req, we, gnt, rvalid;
  logic [NUM_REQ-1:0][13:0]  addr;
  logic [NUM_REQ-1:0][7:0]   wdata, rdata;

  assign req   = {m1_req, m0_req};
  assign we    = {m1_we, m0_we};
  assign addr  = {m1_addr, m0_addr};
  assign wdata = {m1_wdata, m0_wdata};

  logic          prio_q, prio_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [13:0]   addr_q;
  logic [7:0]    do_q;
  logic          sel;
  logic          any_gnt;

  // Preferred requester wins if it asks. Otherwise the other one wins.
  // Reset masks every grant, so nothing reaches the RAM while it is held.
  always_comb begin
    gnt = '0;
    sel = prio_q;
    if (!reset) begin
      if (req[prio_q]) begin
        gnt[prio_q] = 1'b1;
        sel         = prio_q;
      end else if (req[~prio_q]) begin
        gnt[~prio_q] = 1'b1;
        sel          = ~prio_q;
      end
    end
  end

  assign any_gnt = |gnt;
  assign m0_gnt  = gnt[0];
  assign m1_gnt  = gnt[1];

  // The address and data buses keep the last issued command when the RAM is idle.
  assign res_addr = any_gnt ? addr[sel]  : addr_q;
  assign res_do   = any_gnt ? wdata[sel] : do_q;
  assign res_wr   = any_gnt &  we[sel];
  assign res_rd   = any_gnt & ~we[sel];

  // Hold accounting: cnt counts consecutive grants to prio.
  // The HOLD_MAX'th grant in a row hands preference to the other side.
  always_comb begin
    prio_d = prio_q;
    cnt_d  = cnt_q;
    if (any_gnt) begin
      if (sel == prio_q) begin
        if ({1'b0, cnt_q} + (CW + 1)'(1) == HOLD_LIM) begin
          prio_d = ~prio_q;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else if (HOLD_MAX == 1) begin
        // With a hold of one, the next grant goes back to the side that just lost.
        prio_d = ~sel;
        cnt_d  = '0;
      end else begin
        // The non-preferred side won because prio was idle. It becomes the owner
        // and this grant counts as the first grant of its run.
        prio_d = sel;
        cnt_d  = CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q <= 1'b0;
      cnt_q  <= '0;
      addr_q <= '0;
      do_q   <= '0;
    end else begin
      prio_q <= prio_d;
      cnt_q  <= cnt_d;
      if (any_gnt) begin
        addr_q <= addr[sel];
        do_q   <= wdata[sel];
      end
    end
  end

  for (genvar n = 0; n < NUM_REQ; n++) begin : g_rp
    res_arb_rport u_rp (
      .clk_i    (clk),
      .rst_i    (reset),
      .hit_i    (gnt[n] & ~we[n]),
      .di_i     (res_di),
      .rvalid_o (rvalid[n]),
      .rdata_o  (rdata[n])
    );
  end

  assign m0_rvalid = rvalid[0];
  assign m1_rvalid = rvalid[1];
  assign m0_rdata  = rdata[0];
  assign m1_rdata  = rdata[1];

`ifdef RES_ARB_STATS_EN
  // Count cycles in which both requesters ask, so one of them is denied.
  // The counter saturates instead of wrapping.
  logic [15:0] stall_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else if (req[0] && req[1] && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end
  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_res_arb.sv
`timescale 1ns/1ps
module tb_res_arb;
  localparam int HM = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]  treq, twe;
  logic [13:0] taddr [2];
  logic [7:0]  twd   [2];
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [7:0]  m0_rdata, m1_rdata;
  logic        res_rd, res_wr;
  logic [13:0] res_addr;
  logic [7:0]  res_do, res_di;
`ifdef RES_ARB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  res_arb #(.HOLD_MAX(HM)) dut (
    .clk(clk), .reset(reset),
    .m0_req(treq[0]), .m0_we(twe[0]), .m0_addr(taddr[0]), .m0_wdata(twd[0]),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(treq[1]), .m1_we(twe[1]), .m1_addr(taddr[1]), .m1_wdata(twd[1]),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .res_rd(res_rd), .res_wr(res_wr), .res_addr(res_addr), .res_do(res_do),
    .res_di(res_di)
`ifdef RES_ARB_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  function automatic logic [7:0] init_val(int i);
    return 8'(i * 37 + (i >> 8) + 11);
  endfunction

  // RAM: it reads and writes at the negedge.
  logic [7:0] ram [16384];
  initial begin
    logic [7:0] d;
    for (int i = 0; i < 16384; i++) ram[i] = init_val(i);
    forever begin
      @(negedge clk);
      d = ram[res_addr];
      if (res_wr) ram[res_addr] = res_do;
      res_di <= d;
    end
  end

  int vectors = 0, miscompares = 0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One expected record per clock cycle.
  typedef struct {
    bit          rst;
    int          who;
    bit          we;
    logic [13:0] addr;
    logic [7:0]  dout;
    logic [7:0]  rdv;
    logic [15:0] stall;
  } rec_t;
  rec_t expq[$];

  // Reference model. It tracks which side is preferred, how many grants in a
  // row that side has had, and a memory image.
  logic [7:0]  mdl [16384];
  int          mpref, mrun, mstall;
  logic [13:0] mlast_addr;
  logic [7:0]  mlast_do;
  bit          tk [2];

  task automatic model_eval();
    rec_t r;
    int w;
    r.rst = reset; r.who = -1; r.we = 0; r.rdv = '0;
    if (reset) begin
      mpref = 0; mrun = 0; mstall = 0; mlast_addr = '0; mlast_do = '0;
      r.addr = '0; r.dout = '0; r.stall = '0;
    end else begin
      r.stall = 16'(mstall);
      if (treq[0] && treq[1] && mstall < 65535) mstall++;
      if (treq[mpref])        w = mpref;
      else if (treq[1-mpref]) w = 1 - mpref;
      else                    w = -1;
      if (w >= 0) begin
        r.who = w; r.we = twe[w]; r.addr = taddr[w]; r.dout = twd[w];
        if (twe[w]) mdl[taddr[w]] = twd[w];
        else        r.rdv = mdl[taddr[w]];
        mlast_addr = taddr[w]; mlast_do = twd[w];
        if (w == mpref) begin
          mrun++;
          if (mrun == HM) begin mpref = 1 - mpref; mrun = 0; end
        end else if (HM == 1) begin
          mrun = 0;
        end else begin
          mpref = w; mrun = 1;
        end
      end else begin
        r.addr = mlast_addr; r.dout = mlast_do;
      end
    end
    expq.push_back(r);
  endtask

  // Monitor: pops one record per cycle and compares it with the DUT.
  rec_t       prv, cur;
  bit         have_prv = 0;
  logic [7:0] hold_rd [2];
  bit         rvx [2];
  always @(negedge clk) begin
    if (expq.size() != 0) begin
      cur = expq.pop_front();
      chk("m0_gnt", 32'(m0_gnt), 32'(cur.who == 0));
      chk("m1_gnt", 32'(m1_gnt), 32'(cur.who == 1));
      chk("res_rd", 32'(res_rd), 32'(cur.who >= 0 && !cur.we));
      chk("res_wr", 32'(res_wr), 32'(cur.who >= 0 && cur.we));
      chk("res_addr", 32'(res_addr), 32'(cur.addr));
      chk("res_do", 32'(res_do), 32'(cur.dout));
      for (int n = 0; n < 2; n++) begin
        rvx[n] = have_prv && !cur.rst && !prv.rst && prv.who == n && !prv.we;
        if (cur.rst)     hold_rd[n] = '0;
        else if (rvx[n]) hold_rd[n] = prv.rdv;
      end
      chk("m0_rvalid", 32'(m0_rvalid), 32'(rvx[0]));
      chk("m1_rvalid", 32'(m1_rvalid), 32'(rvx[1]));
      chk("m0_rdata", 32'(m0_rdata), 32'(hold_rd[0]));
      chk("m1_rdata", 32'(m1_rdata), 32'(hold_rd[1]));
`ifdef RES_ARB_STATS_EN
      chk("stall_cnt", 32'(stall_cnt), 32'(cur.stall));
`endif
      prv = cur;
      have_prv = 1;
    end
  end

  // Driver: the requesters follow the handshake and see the DUT's grants.
  task automatic edge_();
    @(posedge clk); #1;
    for (int n = 0; n < 2; n++) if (treq[n] && tk[n]) treq[n] = 1'b0;
  endtask

  task automatic settle();
    model_eval();
    @(negedge clk);
    tk[0] = m0_gnt; tk[1] = m1_gnt;
  endtask

  task automatic gen_rd(int n);
    if (!treq[n]) begin
      treq[n] = 1'b1; twe[n] = 1'b0; taddr[n] = 14'($urandom);
    end
  endtask

  task automatic gen_rand(int n);
    if (!treq[n] && $urandom_range(0, 9) < 7) begin
      treq[n]  = 1'b1;
      twe[n]   = 1'($urandom_range(0, 1));
      taddr[n] = ($urandom_range(0, 1) != 0) ? 14'($urandom_range(0, 7)) : 14'($urandom);
      twd[n]   = 8'($urandom);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      edge_(); settle();
      if ((treq & ~{tk[1], tk[0]}) == 2'b00) break;
    end
    chk("drain", 32'(treq & ~{tk[1], tk[0]}), 32'd0);
  endtask

  int p22 [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
  int p25 [9]  = '{1, 1, 1, 1, 0, 0, 0, 0, 1};

  function automatic int who_got();
    return tk[0] ? 0 : (tk[1] ? 1 : -1);
  endfunction

  initial begin
    reset = 1'b1; treq = '0; twe = '0;
    taddr[0] = '0; taddr[1] = '0; twd[0] = '0; twd[1] = '0;
    tk[0] = 0; tk[1] = 0;
    for (int i = 0; i < 16384; i++) mdl[i] = init_val(i);

    // Requests are active during reset. No grant may escape.
    for (int i = 0; i < 3; i++) begin edge_(); gen_rand(0); gen_rand(1); settle(); end

    // Both requesters read continuously, starting right after reset.
    for (int i = 0; i < 12; i++) begin
      edge_();
      if (i == 0) begin reset = 1'b0; treq = '0; end
      gen_rd(0); gen_rd(1); settle();
      chk("pattern_both_rd", 32'(who_got()), 32'(p22[i]));
    end

    // Only m1 requests for three cycles. Then m0 joins.
    for (int i = 0; i < 2; i++) begin edge_(); reset = 1'b1; settle(); end
    for (int i = 0; i < 9; i++) begin
      edge_();
      if (i == 0) begin reset = 1'b0; treq = '0; end
      gen_rd(1);
      if (i >= 3) gen_rd(0);
      settle();
      chk("pattern_m1_first", 32'(who_got()), 32'(p25[i]));
    end

    // m1 writes a value. m0 reads it back in the next cycle.
    drain();
    edge_();
    treq[1] = 1'b1; twe[1] = 1'b1; taddr[1] = 14'h0005; twd[1] = 8'hA7;
    settle();
    edge_();
    treq[0] = 1'b1; twe[0] = 1'b0; taddr[0] = 14'h0005;
    settle();
    edge_(); settle();
    chk("raw_m0_rvalid", 32'(m0_rvalid), 32'd1);
    chk("raw_m0_rdata", 32'(m0_rdata), 32'h00A7);
    chk("raw_m1_rvalid", 32'(m1_rvalid), 32'd0);

    // Random traffic with address reuse.
    for (int i = 0; i < 3000; i++) begin edge_(); gen_rand(0); gen_rand(1); settle(); end

    // Reset arrives in the same cycle as a write. The write must be dropped.
    drain();
    edge_();
    treq = 2'b01; twe[0] = 1'b1; taddr[0] = 14'h3FFF; twd[0] = 8'h3C; reset = 1'b1;
    settle();
    chk("rst_wr_blocked", 32'(res_wr), 32'd0);
    edge_();
    reset = 1'b0; twe[0] = 1'b0;
    settle();
    edge_(); settle();
    chk("rst_old_rvalid", 32'(m0_rvalid), 32'd1);
    chk("rst_old_rdata", 32'(m0_rdata), 32'(init_val(16383)));

`ifdef RES_ARB_STATS_EN
    drain();
    for (int i = 0; i < 65540; i++) begin edge_(); gen_rd(0); gen_rd(1); settle(); end
    chk("stall_saturate", 32'(stall_cnt), 32'h0000FFFF);
`endif

    edge_(); treq = '0; settle();
    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
